// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared pipeline types for the decode-stage hazard unit:
//   fwd_sel_t  : operand source select (RF, EX, MEM, WB)
//   hz_state_t : hazard FSM state (RUN, LU_STALL, MEM_WAIT)
//   DATA_W_DEF / REG_W_DEF : default datapath and register-address widths
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_EX  = 2'd1,
    SEL_MEM = 2'd2,
    SEL_WB  = 2'd3
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the decode operands, the EX/MEM/WB stage status buses and the
// hazard unit results.
//   master : pipeline side (drives stage status, receives stall/forwarding)
//   slave  : hazard unit side
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
);
  // decode
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_is_branch;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  // EX stage
  logic              ex_valid;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_result;
  // MEM stage
  logic              mem_valid;
  logic              mem_regwrite;
  logic              mem_memread;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] mem_load_data;
  logic              mem_done;
  // WB stage
  logic              wb_valid;
  logic              wb_regwrite;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_result;
  // results
  logic              stall;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [1:0]        rs_sel;
  logic [1:0]        rt_sel;
  logic [1:0]        fsm_state;
  logic [CNT_W-1:0]  stall_cnt;
  logic              err_timeout;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_is_branch, id_rs_data, id_rt_data,
    output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_result,
    output mem_valid, mem_regwrite, mem_memread, mem_rd, mem_result, mem_load_data, mem_done,
    output wb_valid, wb_regwrite, wb_rd, wb_result,
    input  stall, rs_fwd, rt_fwd, rs_sel, rt_sel, fsm_state, stall_cnt, err_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_is_branch, id_rs_data, id_rt_data,
    input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_result,
    input  mem_valid, mem_regwrite, mem_memread, mem_rd, mem_result, mem_load_data, mem_done,
    input  wb_valid, wb_regwrite, wb_rd, wb_result,
    output stall, rs_fwd, rt_fwd, rs_sel, rt_sel, fsm_state, stall_cnt, err_timeout
  );

endinterface

// File: rtl/hazard_scoreboard_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Per-source operand forwarding. Matches one decode source address against
// the EX, MEM and WB destinations and selects the youngest producer
// (EX > MEM > WB > RF). An unused source always reads the register file.
// Ports:
//   i_src, i_used, i_rf_data        : decode source address/flag/RF data
//   i_ex_wr,  i_ex_rd,  i_ex_data   : EX writer qualifier, dest, result
//   i_mem_wr, i_mem_rd, i_mem_memread, i_mem_result, i_mem_load_data
//   i_wb_wr,  i_wb_rd,  i_wb_data
//   o_sel, o_data                   : chosen source and operand
//   o_hit_ex, o_hit_mem             : raw stage matches for stall logic
// ---------------------------------------------------------------------------
module fwd_mux
  import hazard_scoreboard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic [REG_W-1:0]  i_src,
  input  logic              i_used,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_ex_wr,
  input  logic [REG_W-1:0]  i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_mem_wr,
  input  logic [REG_W-1:0]  i_mem_rd,
  input  logic              i_mem_memread,
  input  logic [DATA_W-1:0] i_mem_result,
  input  logic [DATA_W-1:0] i_mem_load_data,
  input  logic              i_wb_wr,
  input  logic [REG_W-1:0]  i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output fwd_sel_t          o_sel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hit_ex,
  output logic              o_hit_mem
);

  logic              w_hit_ex;
  logic              w_hit_mem;
  logic              w_hit_wb;
  logic [DATA_W-1:0] w_mem_data;

  assign w_hit_ex   = i_used & i_ex_wr  & (i_src == i_ex_rd);
  assign w_hit_mem  = i_used & i_mem_wr & (i_src == i_mem_rd);
  assign w_hit_wb   = i_used & i_wb_wr  & (i_src == i_wb_rd);
  // A load in MEM forwards the memory word, anything else the ALU result.
  assign w_mem_data = i_mem_memread ? i_mem_load_data : i_mem_result;

  assign o_hit_ex  = w_hit_ex;
  assign o_hit_mem = w_hit_mem;

  // Priority select: youngest matching producer wins.
  always_comb begin
    o_sel  = SEL_RF;
    o_data = i_rf_data;
    if (w_hit_ex) begin
      o_sel  = SEL_EX;
      o_data = i_ex_data;
    end else if (w_hit_mem) begin
      o_sel  = SEL_MEM;
      o_data = w_mem_data;
    end else if (w_hit_wb) begin
      o_sel  = SEL_WB;
      o_data = i_wb_data;
    end else begin
      o_sel  = SEL_RF;
      o_data = i_rf_data;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Decode-stage hazard unit: operand forwarding from EX/MEM/WB, load-use,
// branch-operand and variable-latency memory stalls, a stall-state FSM,
// a saturating stall counter and a sticky memory-timeout flag.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-low reset
//   hz     : hazard_scoreboard_if.slave (stage status in, stall/forwarding,
//            fsm_state, stall_cnt, err_timeout out)
// stall is combinational and is the only output meant for pipeline enables;
// fsm_state is for observability.
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  hazard_scoreboard_if.slave  hz
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic              w_ex_wr;
  logic              w_mem_wr;
  logic              w_wb_wr;
  fwd_sel_t          w_rs_sel;
  fwd_sel_t          w_rt_sel;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic              w_rs_hit_ex;
  logic              w_rt_hit_ex;
  logic              w_rs_hit_mem;
  logic              w_rt_hit_mem;
  logic              w_load_use;
  logic              w_branch_ex;
  logic              w_mem_wait;
  logic              w_stall;
  hz_state_t         w_state_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;

  hz_state_t         r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_err_timeout;

  assign w_ex_wr  = hz.ex_valid  & hz.ex_regwrite;
  assign w_mem_wr = hz.mem_valid & hz.mem_regwrite;
  assign w_wb_wr  = hz.wb_valid  & hz.wb_regwrite;

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .i_src           (hz.id_rs),
    .i_used          (hz.id_rs_used),
    .i_rf_data       (hz.id_rs_data),
    .i_ex_wr         (w_ex_wr),
    .i_ex_rd         (hz.ex_rd),
    .i_ex_data       (hz.ex_result),
    .i_mem_wr        (w_mem_wr),
    .i_mem_rd        (hz.mem_rd),
    .i_mem_memread   (hz.mem_memread),
    .i_mem_result    (hz.mem_result),
    .i_mem_load_data (hz.mem_load_data),
    .i_wb_wr         (w_wb_wr),
    .i_wb_rd         (hz.wb_rd),
    .i_wb_data       (hz.wb_result),
    .o_sel           (w_rs_sel),
    .o_data          (w_rs_data),
    .o_hit_ex        (w_rs_hit_ex),
    .o_hit_mem       (w_rs_hit_mem)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .i_src           (hz.id_rt),
    .i_used          (hz.id_rt_used),
    .i_rf_data       (hz.id_rt_data),
    .i_ex_wr         (w_ex_wr),
    .i_ex_rd         (hz.ex_rd),
    .i_ex_data       (hz.ex_result),
    .i_mem_wr        (w_mem_wr),
    .i_mem_rd        (hz.mem_rd),
    .i_mem_memread   (hz.mem_memread),
    .i_mem_result    (hz.mem_result),
    .i_mem_load_data (hz.mem_load_data),
    .i_wb_wr         (w_wb_wr),
    .i_wb_rd         (hz.wb_rd),
    .i_wb_data       (hz.wb_result),
    .o_sel           (w_rt_sel),
    .o_data          (w_rt_data),
    .o_hit_ex        (w_rt_hit_ex),
    .o_hit_mem       (w_rt_hit_mem)
  );

  // Stall causes. The MEM match is the raw one (not the forwarding winner):
  // an older outstanding load still blocks even when EX also matches.
  // A decode branch may not compare against a value still in EX.
  always_comb begin
    w_load_use  = (w_rs_hit_ex | w_rt_hit_ex) & hz.ex_memread;
    w_branch_ex = hz.id_is_branch & (w_rs_hit_ex | w_rt_hit_ex) & ~hz.ex_memread;
    w_mem_wait  = (w_rs_hit_mem | w_rt_hit_mem) & hz.mem_memread & ~hz.mem_done;
    w_stall     = w_load_use | w_branch_ex | w_mem_wait;
  end

  // Next-state logic; mem-wait takes precedence since the MEM load is older.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait) begin
          w_state_nxt = ST_MEM_WAIT;
        end else if (w_load_use) begin
          w_state_nxt = ST_LU_STALL;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LU_STALL: begin
        if (w_mem_wait) begin
          w_state_nxt = ST_MEM_WAIT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // mem_wait already folds in ~mem_done, so this covers both exits.
        if (w_mem_wait) begin
          w_state_nxt = ST_MEM_WAIT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Wait counter next value: cleared on MEM_WAIT entry, counts MEM_WAIT
  // cycles and parks at MAX_WAIT.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if ((r_state != ST_MEM_WAIT) && (w_state_nxt == ST_MEM_WAIT)) begin
      w_wait_nxt = '0;
    end else if ((r_state == ST_MEM_WAIT) && (r_wait_cnt != WAIT_MAX)) begin
      w_wait_nxt = r_wait_cnt + WAIT_ONE;
    end else begin
      w_wait_nxt = r_wait_cnt;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Sticky timeout: sets on the edge the wait counter reaches MAX_WAIT.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_wait_nxt == WAIT_MAX) begin
      r_err_timeout <= 1'b1;
    end else begin
      r_err_timeout <= r_err_timeout;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign hz.stall       = w_stall;
  assign hz.rs_fwd      = w_rs_data;
  assign hz.rt_fwd      = w_rt_data;
  assign hz.rs_sel      = w_rs_sel;
  assign hz.rt_sel      = w_rt_sel;
  assign hz.fsm_state   = r_state;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.err_timeout = r_err_timeout;

endmodule
